// File: rtl/regbus_arb_pkg.sv
// Shared types and constants for the Bus2Reg round-robin arbiter and its front-ends.
package regbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Front-ends map req_err onto the AXI RRESP/BRESP encodings with these.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width needed to index/count 'value' states, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/regbus_arbiter_if.sv
// Requester-side and Bus2Reg-side signals of the arbiter, bundled for port connection.
interface regbus_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_is_wr;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wr_data;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wr_biten;
    logic [N_REQ-1:0]                 req_ready;
    logic                             req_err;
    logic [DATA_WIDTH-1:0]            rsp_rd_data;

    logic                             bus_req;
    logic                             bus_req_is_wr;
    logic [ADDR_WIDTH-1:0]            bus_addr;
    logic [DATA_WIDTH-1:0]            bus_wr_data;
    logic [DATA_WIDTH-1:0]            bus_wr_biten;
    logic                             bus_ready;
    logic [DATA_WIDTH-1:0]            bus_rd_data;
    logic                             bus_req_stall_wr;
    logic                             bus_req_stall_rd;

    // The arbiter owns the shared register bus.
    modport master (
        input  req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
        output req_ready, req_err, rsp_rd_data,
        output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        input  bus_ready, bus_rd_data, bus_req_stall_wr, bus_req_stall_rd
    );

    modport slave (
        output req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
        input  req_ready, req_err, rsp_rd_data,
        input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        output bus_ready, bus_rd_data, bus_req_stall_wr, bus_req_stall_rd
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1.
module rr_pick
    import regbus_arb_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int GW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    grant,
    output logic             any
);

    // One extra bit so last_grant+N_REQ never overflows before the wrap.
    localparam int CW = GW + 1;

    logic [CW-1:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = {1'b0, last_grant} + CW'(off);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!any && req_valid[cand[GW-1:0]]) begin
                grant = cand[GW-1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing one Bus2Reg register-map port among N_REQ front-ends,
// with a watchdog that aborts accesses the register map never acknowledges.
module regbus_arbiter
    import regbus_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic              ACLK,
    input logic              ARESET,
    regbus_arbiter_if.master bus_if
);

    localparam int GW = clog2_min1(N_REQ);
    localparam int WW = clog2_min1(TIMEOUT + 1);

    arb_state_t            state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_grant_q;
    logic                  hold_wr_q;
    logic [ADDR_WIDTH-1:0] hold_addr_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [DATA_WIDTH-1:0] hold_biten_q;
    logic [WW-1:0]         wd_cnt_q;
    logic [WW-1:0]         wd_cnt_d;
    logic [N_REQ-1:0]      req_ready_q;
    logic                  req_err_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [GW-1:0]         pick_grant;
    logic                  pick_any;
    logic                  stall;
    logic                  timeout_hit;
    logic [N_REQ-1:0]      grant_onehot;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_valid  (bus_if.req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    always_comb begin
        stall        = hold_wr_q ? bus_if.bus_req_stall_wr : bus_if.bus_req_stall_rd;
        wd_cnt_d     = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + 1'b1;
        timeout_hit  = (TIMEOUT != 0) && (wd_cnt_d == WW'(TIMEOUT));
        grant_onehot = N_REQ'(1) << grant_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            hold_wr_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            hold_biten_q <= '0;
            wd_cnt_q     <= '0;
            req_ready_q  <= '0;
            req_err_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q      <= pick_grant;
                        hold_wr_q    <= bus_if.req_is_wr[pick_grant];
                        hold_addr_q  <= bus_if.req_addr[pick_grant];
                        hold_data_q  <= bus_if.req_wr_data[pick_grant];
                        hold_biten_q <= bus_if.req_wr_biten[pick_grant];
                        wd_cnt_q     <= '0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // A completion in the same cycle as the timeout takes priority.
                    if (bus_if.bus_ready) begin
                        rd_data_q   <= hold_wr_q ? '0 : bus_if.bus_rd_data;
                        req_err_q   <= 1'b0;
                        req_ready_q <= grant_onehot;
                        state_q     <= DONE;
                    end else if (!stall) begin
                        wd_cnt_q <= wd_cnt_d;
                        if (timeout_hit) begin
                            rd_data_q   <= '0;
                            req_err_q   <= 1'b1;
                            req_ready_q <= grant_onehot;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    req_ready_q  <= '0;
                    req_err_q    <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // bus_req follows state_q directly so an asynchronous reset drops it at once.
    assign bus_if.bus_req       = (state_q == BUSY) && !stall;
    assign bus_if.bus_req_is_wr = hold_wr_q;
    assign bus_if.bus_addr      = hold_addr_q;
    assign bus_if.bus_wr_data   = hold_data_q;
    assign bus_if.bus_wr_biten  = hold_biten_q;
    assign bus_if.req_ready     = req_ready_q;
    assign bus_if.req_err       = req_err_q;
    assign bus_if.rsp_rd_data   = rd_data_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of round-robin grant order, timing and watchdog.
module tb_regbus_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    localparam int S_IDLE = 0;
    localparam int S_BUSY = 1;
    localparam int S_DONE = 2;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    regbus_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    regbus_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus_if (bif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Staged stimulus, applied shortly after each rising edge.
    logic [N-1:0]         tv_valid = '0;
    logic [N-1:0]         tv_wr    = '0;
    logic [N-1:0][AW-1:0] tv_addr  = '0;
    logic [N-1:0][DW-1:0] tv_wd    = '0;
    logic [N-1:0][DW-1:0] tv_be    = '0;
    logic                 tv_ready = 1'b0;
    logic [DW-1:0]        tv_rd    = '0;
    logic                 tv_swr   = 1'b0;
    logic                 tv_srd   = 1'b0;
    logic                 tv_rst   = 1'b1;
    logic                 auto_rearm = 1'b0;
    logic                 silent     = 1'b0;

    // Reference model of the access in flight.
    int            m_state = S_IDLE;
    int            m_grant = 0;
    int            m_last  = N - 1;
    int            m_cnt   = 0;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wd    = '0;
    logic [DW-1:0] m_be    = '0;
    logic          m_err   = 1'b0;
    logic [DW-1:0] m_rd    = '0;
    int            grant_log[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0t)", tag, act, exp, $time);
        end
    endtask

    // Requester with the smallest forward distance from the last grant wins.
    function automatic int rr_ref(input logic [N-1:0] mask, input int last);
        int best;
        int best_dist;
        int d;
        best      = -1;
        best_dist = N + 1;
        for (int j = 0; j < N; j++) begin
            if (mask[j]) begin
                d = (j - last - 1 + 2 * N) % N;
                if (d < best_dist) begin
                    best_dist = d;
                    best      = j;
                end
            end
        end
        return best;
    endfunction

    task automatic drive();
        ARESET               = tv_rst;
        bif.req_valid        = tv_valid;
        bif.req_is_wr        = tv_wr;
        bif.req_addr         = tv_addr;
        bif.req_wr_data      = tv_wd;
        bif.req_wr_biten     = tv_be;
        bif.bus_ready        = tv_ready;
        bif.bus_rd_data      = tv_rd;
        bif.bus_req_stall_wr = tv_swr;
        bif.bus_req_stall_rd = tv_srd;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] be);
        tv_valid[r] = 1'b1;
        tv_wr[r]    = wr;
        tv_addr[r]  = a;
        tv_wd[r]    = wd;
        tv_be[r]    = be;
    endtask

    // One clock cycle: apply stimulus, compare outputs with the model, advance the model.
    task automatic cycle();
        logic stall_m;
        int   g;
        @(posedge ACLK);
        #2;
        drive();
        #2;
        stall_m = m_wr ? tv_swr : tv_srd;
        if (m_state == S_BUSY) begin
            check("bus_req", bif.bus_req, !stall_m);
            check("bus_req_is_wr", bif.bus_req_is_wr, m_wr);
            check("bus_addr", bif.bus_addr, m_addr);
            check("bus_wr_data", bif.bus_wr_data, m_wd);
            check("bus_wr_biten", bif.bus_wr_biten, m_be);
        end else begin
            check("bus_req_quiet", bif.bus_req, 1'b0);
        end
        if (m_state == S_DONE) begin
            check("req_ready", bif.req_ready, 1 << m_grant);
            check("req_err", bif.req_err, m_err);
            check("rsp_rd_data", bif.rsp_rd_data, m_rd);
        end else begin
            check("req_ready_quiet", bif.req_ready, 0);
        end
        case (m_state)
            S_IDLE: begin
                if (tv_valid != '0) begin
                    g       = rr_ref(tv_valid, m_last);
                    m_grant = g;
                    m_wr    = tv_wr[g];
                    m_addr  = tv_addr[g];
                    m_wd    = tv_wd[g];
                    m_be    = tv_be[g];
                    m_cnt   = 0;
                    silent  = ($urandom_range(0, 3) == 0);
                    grant_log.push_back(g);
                    m_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (tv_ready) begin
                    m_err   = 1'b0;
                    m_rd    = m_wr ? '0 : tv_rd;
                    m_state = S_DONE;
                end else if (!stall_m) begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        m_err   = 1'b1;
                        m_rd    = '0;
                        m_state = S_DONE;
                    end
                end
            end
            default: begin
                m_last  = m_grant;
                m_state = S_IDLE;
            end
        endcase
        if (!auto_rearm) tv_valid = tv_valid & ~bif.req_ready;
    endtask

    task automatic drain();
        int guard;
        guard      = 0;
        auto_rearm = 1'b0;
        while ((tv_valid != '0 || m_state != S_IDLE) && guard < 100) begin
            tv_ready = (m_state == S_BUSY);
            cycle();
            guard++;
        end
        tv_ready = 1'b0;
        check("drain_within_budget", guard < 100, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish, expected finish before 300000");
        $fatal(1, "bench timed out");
    end

    initial begin
        drive();
        @(posedge ACLK);
        #3;
        check("rst_bus_req", bif.bus_req, 1'b0);
        check("rst_req_ready", bif.req_ready, 0);
        check("rst_req_err", bif.req_err, 1'b0);
        check("rst_rsp_rd_data", bif.rsp_rd_data, 0);
        check("rst_bus_addr", bif.bus_addr, 0);
        check("rst_bus_wr_biten", bif.bus_wr_biten, 0);
        tv_rst = 1'b0;
        cycle();

        // Single read from requester 0, regmap answers on the second BUSY cycle.
        grant_log.delete();
        set_req(0, 1'b0, 32'h10, '0, '0);
        cycle();
        cycle();
        check("t1_bus_req_cycle1", bif.bus_req, 1'b1);
        tv_ready = 1'b1;
        tv_rd    = 32'hDEADBEEF;
        cycle();
        tv_ready = 1'b0;
        tv_rd    = 32'h0BAD0BAD;
        cycle();
        check("t1_req_ready", bif.req_ready, 3'b001);
        check("t1_rd_data", bif.rsp_rd_data, 32'hDEADBEEF);
        check("t1_req_err", bif.req_err, 1'b0);
        check("t1_first_grant", grant_log[0], 0);
        cycle();

        // All three requesters continuously valid.
        grant_log.delete();
        set_req(0, 1'b0, 32'h100, '0, '0);
        set_req(1, 1'b1, 32'h104, 32'h11111111, 32'hFFFFFFFF);
        set_req(2, 1'b0, 32'h108, '0, '0);
        auto_rearm = 1'b1;
        for (int k = 0; k < 40 && grant_log.size() < 6; k++) begin
            tv_ready = (m_state == S_BUSY);
            cycle();
        end
        auto_rearm = 1'b0;
        check("t2_grant_count", grant_log.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            check("t2_grant_order", grant_log[k], (1 + k) % N);
        end
        drain();

        // Write stalled for five cycles mid-access; the read stall must not matter.
        set_req(1, 1'b1, 32'h20, 32'h12345678, 32'h0000FFFF);
        tv_srd = 1'b1;
        cycle();
        cycle();
        tv_swr = 1'b1;
        repeat (5) begin
            cycle();
            check("t3_stalled_bus_req", bif.bus_req, 1'b0);
        end
        tv_swr = 1'b0;
        repeat (2) cycle();
        check("t3_biten", bif.bus_wr_biten, 32'h0000FFFF);
        tv_ready = 1'b1;
        cycle();
        tv_ready = 1'b0;
        cycle();
        check("t3_req_ready", bif.req_ready, 3'b010);
        check("t3_req_err", bif.req_err, 1'b0);
        tv_srd = 1'b0;
        cycle();

        // Silent regmap: timeout after four BUSY cycles.
        set_req(2, 1'b0, 32'h30, '0, '0);
        tv_rd = 32'h5555AAAA;
        repeat (6) cycle();
        check("t4_req_ready", bif.req_ready, 3'b100);
        check("t4_req_err", bif.req_err, 1'b1);
        check("t4_rd_data", bif.rsp_rd_data, 0);
        cycle();

        // Completion on the cycle the timeout would fire.
        set_req(2, 1'b0, 32'h34, '0, '0);
        repeat (4) cycle();
        tv_ready = 1'b1;
        cycle();
        tv_ready = 1'b0;
        cycle();
        check("t4b_req_ready", bif.req_ready, 3'b100);
        check("t4b_req_err", bif.req_err, 1'b0);
        check("t4b_rd_data", bif.rsp_rd_data, 32'h5555AAAA);
        cycle();

        // Reset pulse in the middle of an access.
        set_req(1, 1'b1, 32'h50, 32'hA5A5A5A5, 32'hFFFF0000);
        repeat (3) cycle();
        check("t5_pre_bus_req", bif.bus_req, 1'b1);
        #1;
        tv_rst = 1'b1;
        ARESET = 1'b1;
        #1;
        check("t5_bus_req", bif.bus_req, 1'b0);
        check("t5_req_ready", bif.req_ready, 0);
        check("t5_rd_data", bif.rsp_rd_data, 0);
        check("t5_bus_addr", bif.bus_addr, 0);
        check("t5_bus_wr_data", bif.bus_wr_data, 0);
        m_state = S_IDLE;
        m_last  = N - 1;
        grant_log.delete();
        set_req(0, 1'b0, 32'h60, '0, '0);
        tv_rst = 1'b0;
        drain();
        check("t5_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t5_first_after_reset", grant_log[0], 0);
            check("t5_second_after_reset", grant_log[1], 1);
        end

        // Requester 1 withdraws mid-access; the held request must still complete.
        set_req(1, 1'b1, 32'h40, 32'hCAFEF00D, 32'hFFFFFFFF);
        cycle();
        cycle();
        tv_valid[1] = 1'b0;
        tv_addr[1]  = 32'h00000BAD;
        tv_wd[1]    = '0;
        cycle();
        check("t6_held_addr", bif.bus_addr, 32'h40);
        check("t6_held_data", bif.bus_wr_data, 32'hCAFEF00D);
        tv_ready = 1'b1;
        cycle();
        tv_ready = 1'b0;
        cycle();
        check("t6_req_ready", bif.req_ready, 3'b010);
        cycle();

        // Randomized traffic, stalls, stray bus_ready and silent accesses.
        for (int it = 0; it < 500; it++) begin
            for (int r = 0; r < N; r++) begin
                if (!tv_valid[r] && $urandom_range(0, 2) == 0) begin
                    set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
                end
            end
            tv_swr = ($urandom_range(0, 3) == 0);
            tv_srd = ($urandom_range(0, 3) == 0);
            tv_rd  = $urandom;
            if (m_state == S_BUSY) tv_ready = !silent && ($urandom_range(0, 2) == 0);
            else                   tv_ready = ($urandom_range(0, 3) == 0);
            cycle();
        end
        tv_swr = 1'b0;
        tv_srd = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
